vote_logger: RTL and testbench

VOTE_LOGGER -- requirements
Module: vote_logger

---
 rtl/vote_logger_if.sv | 40 ++++
 rtl/vote_logger.sv | 139 +++++++++++++
 tb/tb_vote_logger.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vote_logger_if.sv
// Purpose : groups the voting-panel inputs and the tally/status outputs of vote_logger.
// Latency : none (wires only).
// Backpressure: none; buttons are level signals, pulses are single-cycle and unacknowledged.
//
// Signals:
//   mode                               0 = voting, 1 = result mode
//   candidate1_button..4_button        debounced, clock-synchronous, high = pressed
//   candidate1_vote..4_vote   [7:0]    registered tallies
//   valid_vote_casted                  one-cycle pulse per accepted vote
//   invalid_press                      one-cycle pulse per rejected multi-button press
//   busy                               high whenever the logger is not idle
// master = panel/testbench side, slave = vote_logger side.
interface vote_logger_if;
    logic       mode;
    logic       candidate1_button;
    logic       candidate2_button;
    logic       candidate3_button;
    logic       candidate4_button;
    logic [7:0] candidate1_vote;
    logic [7:0] candidate2_vote;
    logic [7:0] candidate3_vote;
    logic [7:0] candidate4_vote;
    logic       valid_vote_casted;
    logic       invalid_press;
    logic       busy;

    modport master (
        output mode,
        output candidate1_button, candidate2_button, candidate3_button, candidate4_button,
        input  candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
        input  valid_vote_casted, invalid_press, busy
    );

    modport slave (
        input  mode,
        input  candidate1_button, candidate2_button, candidate3_button, candidate4_button,
        output candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote,
        output valid_vote_casted, invalid_press, busy
    );
endinterface

// File: rtl/vote_logger.sv
// Purpose : four-candidate vote counter with press lockout, release detection and multi-press rejection.
// Latency : 1 cycle from the sampled press to valid_vote_casted and the tally update.
// Backpressure: none; presses arriving while busy are ignored until all buttons are released.
//
// Ports:
//   clock   sole clock, rising edge
//   reset   asynchronous active-low reset, clears all state
//   bus     vote_logger_if.slave (mode, four buttons, four 8-bit tallies, pulses, busy)
// Parameter LOCKOUT_CYCLES (1 .. 2^24-1): cycles spent ignoring buttons after each vote.
// Build option: define VOTE_SATURATE_EN to make tallies stick at 255; otherwise they wrap to 0.
module vote_logger #(
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic          clock,
    input  logic          reset,
    vote_logger_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CAST         = 2'd1,
        LOCKOUT      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [23:0] LOCK_LAST = 24'(LOCKOUT_CYCLES - 1);

    state_t      state_q;
    logic [23:0] lock_cnt_q;
    logic [7:0]  tally_q [4];
    logic        vld_q;
    logic        inv_q;
    logic        busy_q;

    logic [3:0]  btn_vec;
    logic        any_press;
    logic        one_press;
    logic        multi_press;
    logic [1:0]  sel_idx;
    logic [7:0]  sel_tally_d;

    assign btn_vec = {bus.candidate4_button, bus.candidate3_button,
                      bus.candidate2_button, bus.candidate1_button};

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign any_press   = (btn_vec != 4'd0);
    assign one_press   = any_press && ((btn_vec & (btn_vec - 4'd1)) == 4'd0);
    assign multi_press = any_press && !one_press;

    always_comb begin
        sel_idx = 2'd0;
        case (btn_vec)
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase
    end

    // The increment is committed on the accepting edge itself so the new
    // tally and the pulse appear together during the CAST cycle; a mode
    // change inside CAST therefore cannot cancel an already-counted vote.
`ifdef VOTE_SATURATE_EN
    assign sel_tally_d = (tally_q[sel_idx] == 8'hFF) ? 8'hFF : tally_q[sel_idx] + 8'd1;
`else
    assign sel_tally_d = tally_q[sel_idx] + 8'd1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            vld_q      <= 1'b0;
            inv_q      <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tally_q[i] <= '0;
            end
        end else begin
            vld_q <= 1'b0;
            inv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.mode) begin
                        state_q <= WAIT_RELEASE;
                        busy_q  <= 1'b1;
                    end else if (one_press) begin
                        state_q          <= CAST;
                        tally_q[sel_idx] <= sel_tally_d;
                        vld_q            <= 1'b1;
                        busy_q           <= 1'b1;
                    end else if (multi_press) begin
                        state_q <= WAIT_RELEASE;
                        inv_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end

                CAST: begin
                    lock_cnt_q <= '0;
                    state_q    <= bus.mode ? WAIT_RELEASE : LOCKOUT;
                end

                LOCKOUT: begin
                    // Buttons are deliberately not looked at here.
                    if (bus.mode || (lock_cnt_q == LOCK_LAST)) begin
                        lock_cnt_q <= '0;
                        state_q    <= WAIT_RELEASE;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 24'd1;
                    end
                end

                WAIT_RELEASE: begin
                    // A held button must drop before another vote, and result
                    // mode parks the logger here.
                    if (!bus.mode && !any_press) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.candidate1_vote   = tally_q[0];
    assign bus.candidate2_vote   = tally_q[1];
    assign bus.candidate3_vote   = tally_q[2];
    assign bus.candidate4_vote   = tally_q[3];
    assign bus.valid_vote_casted = vld_q;
    assign bus.invalid_press     = inv_q;
    assign bus.busy              = busy_q;

endmodule

// File: tb/tb_vote_logger.sv
// Purpose : self-checking bench for vote_logger against a rule-level reference model.
// Latency : model expectations are compared 1 ns after every rising edge.
// Backpressure: not applicable.
module tb_vote_logger;
    localparam int LOCK = 16;

    logic clock;
    logic reset;

    vote_logger_if bus ();

    vote_logger #(.LOCKOUT_CYCLES(LOCK)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: votes counted per candidate plus three facts about
    // the logger -- just accepted a vote, cycles of lockout still owed,
    // and whether it is waiting for every button to be let go.
    int m_tally [4];
    bit m_vld;
    bit m_inv;
    bit m_cast;
    bit m_wait;
    int m_lock;

    function automatic int bump(input int t);
`ifdef VOTE_SATURATE_EN
        return (t >= 255) ? 255 : t + 1;
`else
        return (t + 1) % 256;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_tally[i] = 0;
        m_vld = 0; m_inv = 0; m_cast = 0; m_wait = 0; m_lock = 0;
    endtask

    task automatic model_step(input bit md, input logic [3:0] b);
        int n;
        m_vld = 0;
        m_inv = 0;
        n = $countones(b);
        if (m_cast) begin
            m_cast = 0;
            if (md) m_wait = 1;
            else    m_lock = LOCK;
        end else if (m_lock > 0) begin
            if (md) begin
                m_lock = 0;
                m_wait = 1;
            end else begin
                m_lock--;
                if (m_lock == 0) m_wait = 1;
            end
        end else if (m_wait) begin
            if (!md && n == 0) m_wait = 0;
        end else if (md) begin
            m_wait = 1;
        end else if (n == 1) begin
            for (int k = 0; k < 4; k++) begin
                if (b[k]) m_tally[k] = bump(m_tally[k]);
            end
            m_vld  = 1;
            m_cast = 1;
        end else if (n > 1) begin
            m_inv  = 1;
            m_wait = 1;
        end
    endtask

    function automatic bit model_busy();
        return m_cast || (m_lock > 0) || m_wait;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("vote1",   32'(bus.candidate1_vote), m_tally[0]);
        chk("vote2",   32'(bus.candidate2_vote), m_tally[1]);
        chk("vote3",   32'(bus.candidate3_vote), m_tally[2]);
        chk("vote4",   32'(bus.candidate4_vote), m_tally[3]);
        chk("valid",   32'(bus.valid_vote_casted), int'(m_vld));
        chk("invalid", 32'(bus.invalid_press), int'(m_inv));
        chk("busy",    32'(bus.busy), int'(model_busy()));
        chk("exclusive_pulses", 32'(bus.valid_vote_casted & bus.invalid_press), 0);
    endtask

    task automatic set_in(input bit md, input logic [3:0] b);
        bus.mode              = md;
        bus.candidate1_button = b[0];
        bus.candidate2_button = b[1];
        bus.candidate3_button = b[2];
        bus.candidate4_button = b[3];
    endtask

    function automatic logic [3:0] cur_btn();
        return {bus.candidate4_button, bus.candidate3_button,
                bus.candidate2_button, bus.candidate1_button};
    endfunction

    // One clock: model consumes the inputs present at the edge, DUT is checked 1 ns later.
    task automatic tick();
        bit         md;
        logic [3:0] b;
        @(posedge clock);
        md = bus.mode;
        b  = cur_btn();
        model_step(md, b);
        #1;
        check_all();
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (bus.busy && n < max_cycles) begin
            tick();
            n++;
        end
        chk("idle_bound", 32'(bus.busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bc;
        int         pulses;
        logic [3:0] rb;

        // Reset state, checked without any clock edge involvement.
        reset = 1'b0;
        set_in(0, 4'b0000);
        model_reset();
        #2;
        check_all();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Single-cycle press of candidate 2: pulse after 1 cycle, busy for 1+16+1.
        set_in(0, 4'b0010);
        tick();
        chk("c2_pulse", 32'(bus.valid_vote_casted), 1);
        set_in(0, 4'b0000);
        bc = bus.busy ? 1 : 0;
        for (int n = 0; n < 40 && bus.busy; n++) begin
            tick();
            if (bus.busy) bc++;
        end
        chk("busy_len", 32'(bc), 18);
        chk("c2_after", 32'(bus.candidate2_vote), 1);

        // Candidate 3 held for 100 cycles yields a single vote.
        set_in(0, 4'b0100);
        pulses = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (bus.valid_vote_casted) pulses++;
        end
        chk("held_pulses", 32'(pulses), 1);
        set_in(0, 4'b0000);
        tick();
        chk("idle_after_release", 32'(bus.busy), 0);
        chk("c3_after", 32'(bus.candidate3_vote), 1);

        // Candidates 1 and 4 together: rejected, parked until both released.
        set_in(0, 4'b1001);
        tick();
        chk("multi_invalid", 32'(bus.invalid_press), 1);
        repeat (4) tick();
        set_in(0, 4'b1000);
        repeat (3) tick();
        chk("multi_still_busy", 32'(bus.busy), 1);
        set_in(0, 4'b0000);
        tick();
        chk("multi_released", 32'(bus.busy), 0);

        // Second candidate 1 press inside the lockout window is ignored.
        set_in(0, 4'b0001);
        tick();
        set_in(0, 4'b0000);
        repeat (5) tick();
        set_in(0, 4'b0001);
        repeat (3) tick();
        set_in(0, 4'b0000);
        wait_idle(40);
        chk("c1_lockout", 32'(bus.candidate1_vote), 1);

        // Result mode with candidate 2 held, then back to voting still held.
        pulses = 0;
        set_in(1, 4'b0010);
        for (int n = 0; n < 6; n++) begin
            tick();
            if (bus.valid_vote_casted) pulses++;
        end
        set_in(0, 4'b0010);
        for (int n = 0; n < 6; n++) begin
            tick();
            if (bus.valid_vote_casted) pulses++;
        end
        chk("mode_no_vote", 32'(pulses), 0);
        set_in(0, 4'b0000);
        tick();
        set_in(0, 4'b0010);
        tick();
        chk("repress_vote", 32'(bus.candidate2_vote), 2);
        set_in(0, 4'b0000);
        wait_idle(40);

        // 256 votes for candidate 4, then one more.
        for (int v = 0; v < 256; v++) begin
            set_in(0, 4'b1000);
            tick();
            set_in(0, 4'b0000);
            wait_idle(40);
        end
`ifdef VOTE_SATURATE_EN
        chk("c4_256", 32'(bus.candidate4_vote), 255);
`else
        chk("c4_256", 32'(bus.candidate4_vote), 0);
`endif
        set_in(0, 4'b1000);
        tick();
        chk("c4_257_pulse", 32'(bus.valid_vote_casted), 1);
        set_in(0, 4'b0000);
        wait_idle(40);

        // Randomised traffic against the model.
        rb = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: rb = 4'b0000;
                1: rb = 4'b0001 << $urandom_range(0, 3);
                2: rb = 4'($urandom_range(0, 15));
                default: rb = rb;
            endcase
            set_in($urandom_range(0, 9) == 0, rb);
            tick();
        end
        set_in(0, 4'b0000);
        wait_idle(40);

        // Reset dropped mid-lockout clears everything asynchronously.
        set_in(0, 4'b0100);
        tick();
        set_in(0, 4'b0000);
        repeat (4) tick();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_busy", 32'(bus.busy), 0);

        // Button already held when reset is released is taken on the first edge.
        set_in(0, 4'b0001);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        chk("held_through_reset", 32'(bus.candidate1_vote), 1);
        set_in(0, 4'b0000);
        wait_idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
